// File: rtl/johnson_decoder.sv
// Receive-side checker for a Johnson code bus: decodes each sampled code to an index
// and one-hot vector, checks that successive codes follow the Johnson sequence, and tracks lock.
module johnson_decoder #(
    parameter  int WIDTH    = 4,
    parameter  int LOCK_CNT = 3,
    localparam int IW       = $clog2(2*WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   j_in,
    input  logic               j_valid,
    output logic [IW-1:0]      state_idx,
    output logic [2*WIDTH-1:0] state_onehot,
    output logic               code_legal,
    output logic               locked,
    output logic               err_pulse,
    output logic [7:0]         err_cnt
);

    localparam int N  = 2*WIDTH;
    localparam int RW = $clog2(LOCK_CNT+1);

    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

    state_t            state_q;
    logic [RW-1:0]     run_q;
    logic [IW-1:0]     state_idx_q;
    logic [N-1:0]      onehot_q;
    logic              code_legal_q;
    logic              err_pulse_q;
    logic [7:0]        err_cnt_q;

    int                pop;
    int                dec;
    logic [WIDTH-1:0]  ref_code;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     prev_plus1;
    logic              legal;
    logic              is_next;
    logic              is_hold;
    logic              err_now;
    logic [RW-1:0]     run_nxt;

    // Index from popcount, then rebuild the canonical code for that index to judge legality.
    always_comb begin
        pop = 0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + int'(j_in[i]);
        end
        dec = j_in[WIDTH-1] ? (N - pop) : pop;
        for (int i = 0; i < WIDTH; i++) begin
            ref_code[i] = (dec <= WIDTH) ? (i < dec) : (i >= dec - WIDTH);
        end
    end

    // state_idx_q only changes on legal samples, so it doubles as the previous-index register.
    always_comb begin
        idx        = IW'(dec);
        legal      = (ref_code == j_in);
        prev_plus1 = (state_idx_q == IW'(N-1)) ? '0 : state_idx_q + IW'(1);
        is_next    = (idx == prev_plus1);
        is_hold    = (idx == state_idx_q);
        err_now    = j_valid && (!legal || (state_q == LOCKED && !is_next && !is_hold));
        if (run_q == '0) begin
            run_nxt = RW'(1);
        end else if (is_next) begin
            run_nxt = run_q + RW'(1);
        end else if (is_hold) begin
            run_nxt = run_q;
        end else begin
            run_nxt = RW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= UNLOCKED;
            run_q        <= '0;
            state_idx_q  <= '0;
            onehot_q     <= '0;
            code_legal_q <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            err_pulse_q <= err_now;
            if (err_now && err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
            if (j_valid) begin
                if (!legal) begin
                    code_legal_q <= 1'b0;
                    run_q        <= '0;
                    state_q      <= UNLOCKED;
                end else begin
                    code_legal_q <= 1'b1;
                    state_idx_q  <= idx;
                    onehot_q     <= {{(N-1){1'b0}}, 1'b1} << idx;
                    case (state_q)
                        LOCKED: begin
                            if (!is_next && !is_hold) begin
                                state_q <= UNLOCKED;
                                run_q   <= RW'(1);
                            end
                        end
                        default: begin
                            run_q <= run_nxt;
                            if (run_nxt == RW'(LOCK_CNT)) begin
                                state_q <= LOCKED;
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign state_idx    = state_idx_q;
    assign state_onehot = onehot_q;
    assign code_legal   = code_legal_q;
    assign locked       = (state_q == LOCKED);
    assign err_pulse    = err_pulse_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Bench for johnson_decoder: table-driven reference model feeding an expected-value queue,
// directed lock/error/saturation scenarios, async reset, then a random sequence.
module tb_johnson_decoder;

    localparam int WIDTH    = 4;
    localparam int LOCK_CNT = 3;
    localparam int N        = 2*WIDTH;
    localparam int IW       = 3;
    localparam int VW       = IW + N + 3 + 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] j_in;
    logic             j_valid;
    logic [IW-1:0]    state_idx;
    logic [N-1:0]     state_onehot;
    logic             code_legal;
    logic             locked;
    logic             err_pulse;
    logic [7:0]       err_cnt;
    logic [VW-1:0]    out_vec;

    int n_vec  = 0;
    int n_miss = 0;
    logic [VW-1:0] exp_q[$];

    logic [3:0] codes   [0:7] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                                  4'b1111, 4'b1110, 4'b1100, 4'b1000};
    logic [3:0] illegal [0:7] = '{4'b0101, 4'b1011, 4'b0010, 4'b0100,
                                  4'b1001, 4'b1010, 4'b1101, 4'b0110};

    bit       m_locked;
    int       m_run;
    int       m_idx;
    logic [7:0] m_oh;
    bit       m_legal;
    bit       m_pulse;
    int       m_cnt;

    johnson_decoder #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT)) dut (
        .clk          (clk),
        .rst          (rst),
        .j_in         (j_in),
        .j_valid      (j_valid),
        .state_idx    (state_idx),
        .state_onehot (state_onehot),
        .code_legal   (code_legal),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    assign out_vec = {state_idx, state_onehot, code_legal, locked, err_pulse, err_cnt};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_run = 0; m_idx = 0; m_oh = '0;
        m_legal = 0; m_pulse = 0; m_cnt = 0;
    endtask

    function automatic logic [VW-1:0] model_vec();
        return {3'(m_idx), m_oh, m_legal, m_locked, m_pulse, 8'(m_cnt)};
    endfunction

    task automatic model_step(input logic [3:0] j, input logic v);
        int k;
        bit nxt;
        bit hold;
        m_pulse = 0;
        if (!v) return;
        k = -1;
        for (int i = 0; i < N; i++) if (codes[i] == j) k = i;
        if (k < 0) begin
            m_legal = 0; m_pulse = 1; m_run = 0; m_locked = 0;
            if (m_cnt < 255) m_cnt++;
            return;
        end
        nxt  = (k == (m_idx + 1) % N);
        hold = (k == m_idx);
        if (m_locked) begin
            if (!nxt && !hold) begin
                m_pulse = 1; m_locked = 0; m_run = 1;
                if (m_cnt < 255) m_cnt++;
            end
        end else begin
            if (m_run == 0)   m_run = 1;
            else if (nxt)     m_run++;
            else if (!hold)   m_run = 1;
            if (m_run >= LOCK_CNT) m_locked = 1;
        end
        m_idx = k; m_oh = 8'b1 << k; m_legal = 1;
    endtask

    task automatic step(input string tag, input logic [3:0] j, input logic v);
        logic [VW-1:0] e;
        j_in = j; j_valid = v;
        model_step(j, v);
        exp_q.push_back(model_vec());
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check(tag, out_vec, e);
    endtask

    initial begin
        int ridx;
        int r;
        rst = 1'b0; j_in = 4'b0101; j_valid = 1'b1;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            check("rst_hold", out_vec, '0);
        end
        rst = 1'b1;

        step("t2_s1", 4'b0001, 1);
        step("t2_s2", 4'b0011, 1);
        step("t2_s3", 4'b0111, 1);
        check("t2_locked", locked, 1);
        check("t2_idx", state_idx, 3);
        check("t2_onehot", state_onehot, 8'b0000_1000);
        check("t2_errcnt", err_cnt, 0);

        foreach (codes[i]) if (i >= 4) step("t3_walk", codes[i], 1);
        step("t3_wrap", 4'b0000, 1);
        step("t3_after", 4'b0001, 1);
        check("t3_locked", locked, 1);
        check("t3_idx", state_idx, 1);
        check("t3_errcnt", err_cnt, 0);

        step("t4_illegal", 4'b0101, 1);
        check("t4_pulse", err_pulse, 1);
        check("t4_errcnt", err_cnt, 1);
        check("t4_locked", locked, 0);
        check("t4_idx", state_idx, 1);
        step("t4_relock0", 4'b0000, 1);
        check("t4_pulse_once", err_pulse, 0);
        step("t4_relock1", 4'b0001, 1);
        step("t4_relock2", 4'b0011, 1);
        check("t4_relocked", locked, 1);

        step("t5_jump", 4'b1110, 1);
        check("t5_pulse", err_pulse, 1);
        check("t5_errcnt", err_cnt, 2);
        check("t5_locked", locked, 0);
        check("t5_idx", state_idx, 5);
        step("t5_s1", 4'b1100, 1);
        step("t5_s2", 4'b1000, 1);
        check("t5_locked_again", locked, 1);
        check("t5_idx7", state_idx, 7);

        repeat (4) step("t6_idle", 4'($urandom_range(0, 15)), 0);
        repeat (3) step("t6_hold", 4'b1000, 1);
        check("t6_idx", state_idx, 7);
        check("t6_locked", locked, 1);
        for (int i = 0; i < 260; i++) step("t6_sat", illegal[i % 8], 1);
        check("t6_errcnt_sat", err_cnt, 255);
        check("t6_pulse_sat", err_pulse, 1);

        step("t7_lock0", 4'b0000, 1);
        step("t7_lock1", 4'b0001, 1);
        step("t7_lock2", 4'b0011, 1);
        check("t7_locked", locked, 1);
        #2 rst = 1'b0;
        #1 check("t7_async_rst", out_vec, '0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        ridx = 0;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin
                ridx = (ridx + 1) % N;
                step("rnd_next", codes[ridx], 1);
            end else if (r < 80) begin
                step("rnd_hold", codes[ridx], 1);
            end else if (r < 90) begin
                step("rnd_any", 4'($urandom_range(0, 15)), 1);
            end else begin
                step("rnd_idle", 4'($urandom_range(0, 15)), 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
